// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of a 4-digit seven-segment display with minimum hold and digit scan
module seg_display_arbiter #(
  parameter int N_REQ       = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  data,
  output logic [N_REQ-1:0]     grant,
  output logic                 owner_vld,
  output logic [3:0]           an,
  output logic [7:0]           seg
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);
  typedef enum logic {IDLE, OWN} state_t;
  state_t          state;
  logic [IW-1:0]   owner, rr_ptr, pick;
  logic [HW-1:0]   hold_cnt;
  logic [RW-1:0]   refresh_cnt;
  logic [1:0]      digit;
  logic [15:0]     value;
  logic [N_REQ-1:0] mask;
  logic            pick_vld, drop, take, go_idle, own_nxt;
  int              j;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction
  // while owned, rr_ptr equals the owner, so masking the grant excludes the owner from the rotation
  assign mask = state == OWN ? req & ~grant : req;
  // round-robin search: walk from farthest to nearest after rr_ptr so the nearest requester wins
  always_comb begin
    pick_vld = 1'b0;
    pick = rr_ptr;
    j = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (mask[IW'(j)]) begin
        pick_vld = 1'b1;
        pick = IW'(j);
      end
    end
  end
  // ownership decisions; a drop takes priority over hold expiry
  always_comb begin
    drop    = state == OWN && !req[owner];
    take    = pick_vld && (state == IDLE || drop || hold_cnt == HMAX);
    go_idle = drop && !pick_vld;
    own_nxt = take || (state == OWN && !go_idle);
  end
  // arbitration FSM with registered grant outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= IW'(N_REQ - 1);
      hold_cnt  <= '0;
      grant     <= '0;
      owner_vld <= 1'b0;
    end else if (take) begin
      state     <= OWN;
      owner     <= pick;
      rr_ptr    <= pick;
      hold_cnt  <= '0;
      grant     <= N_REQ'(1) << pick;
      owner_vld <= 1'b1;
    end else if (go_idle) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      grant     <= '0;
      owner_vld <= 1'b0;
    end else if (state == OWN && hold_cnt != HMAX) begin
      hold_cnt  <= hold_cnt + 1'b1;
    end
  end
  // free-running digit scan and live copy of the owner's display word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit       <= '0;
      value       <= '0;
    end else begin
      refresh_cnt <= refresh_cnt == RMAX ? '0 : refresh_cnt + 1'b1;
      digit       <= refresh_cnt == RMAX ? digit + 1'b1 : digit;
      value       <= state == OWN ? data[16*int'(owner) +: 16] : '0;
    end
  end
  // registered pin drivers; blank whenever the display is unowned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'hF;
      seg <= 8'hFF;
    end else begin
      an  <= own_nxt ? ~(4'b0001 << digit) : 4'hF;
      seg <= own_nxt ? {1'b1, hex7(value[4*digit +: 4])} : 8'hFF;
    end
  end
endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed and random checks of seg_display_arbiter against a behavioural model
module tb_seg_display_arbiter;
  localparam int N = 4, R = 4, H = 10;
  logic clk = 0, reset = 0;
  logic [N-1:0] req = '0, grant;
  logic [16*N-1:0] data = '0;
  logic owner_vld;
  logic [3:0] an;
  logic [7:0] seg;
  int errs = 0, checks = 0;
  int m_own, m_hold, m_ptr, m_ref, m_dig;
  logic [15:0] m_val;
  logic [3:0] m_an;
  logic [7:0] m_seg;
  logic [6:0] hexd [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg_display_arbiter #(.N_REQ(N), .REFRESH_DIV(R), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data),
    .grant(grant), .owner_vld(owner_vld), .an(an), .seg(seg));

  always #5 clk = ~clk;

  function automatic int next_req(input int from, input int excl, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (from + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_hold = 0; m_ptr = N - 1; m_ref = 0; m_dig = 0;
    m_val = '0; m_an = 4'hF; m_seg = 8'hFF;
  endtask

  task automatic model_step();
    int n_own, n_hold, n_ptr, nx;
    logic [15:0] v;
    n_own = m_own; n_hold = m_hold; n_ptr = m_ptr;
    if (m_own < 0) begin
      nx = next_req(m_ptr, -1, req);
      if (nx >= 0) begin n_own = nx; n_hold = 0; n_ptr = nx; end
    end else begin
      nx = next_req(m_own, m_own, req);
      if (!req[m_own]) begin
        n_own = nx; n_hold = 0;
        if (nx >= 0) n_ptr = nx;
      end else if (m_hold == H - 1 && nx >= 0) begin
        n_own = nx; n_hold = 0; n_ptr = nx;
      end else if (m_hold < H - 1) n_hold = m_hold + 1;
    end
    v = m_val;
    m_an  = n_own >= 0 ? ~(4'b0001 << m_dig) : 4'hF;
    m_seg = n_own >= 0 ? {1'b1, hexd[(v >> (4*m_dig)) & 16'hF]} : 8'hFF;
    m_val = m_own >= 0 ? data[16*m_own +: 16] : 16'h0;
    if (m_ref == R - 1) m_dig = (m_dig + 1) % 4;
    m_ref = (m_ref + 1) % R;
    m_own = n_own; m_hold = n_hold; m_ptr = n_ptr;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] eg;
    eg = m_own >= 0 ? N'(1) << m_own : '0;
    checks++;
    assert (grant === eg) else begin errs++; $error("FAIL %s grant got=%b exp=%b", tag, grant, eg); end
    checks++;
    assert (owner_vld === (m_own >= 0)) else begin errs++; $error("FAIL %s owner_vld got=%b exp=%b", tag, owner_vld, m_own >= 0); end
    checks++;
    assert (an === m_an) else begin errs++; $error("FAIL %s an got=%b exp=%b", tag, an, m_an); end
    checks++;
    assert (seg === m_seg) else begin errs++; $error("FAIL %s seg got=%h exp=%h", tag, seg, m_seg); end
  endtask

  task automatic tick(input logic [N-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step();
    #1 check_all(tag);
  endtask

  task automatic expect_grant(input logic [N-1:0] g, input string tag);
    checks++;
    assert (grant === g) else begin errs++; $error("FAIL %s grant got=%b exp=%b", tag, grant, g); end
  endtask

  initial begin
    int since;
    model_reset();
    #12 check_all("reset");
    @(negedge clk) reset = 1;
    // 1: idle with no requests
    for (int i = 0; i < 50; i++) tick(4'b0000, "idle");
    // 2: req0 and req2, owner 0 shows 1234
    data[15:0] = 16'h1234;
    data[47:32] = 16'hF0F0;
    tick(4'b0001, "grant0");
    expect_grant(4'b0001, "first_grant");
    for (int i = 0; i < 3; i++) tick(4'b0001, "own0");
    // 3: req2 raised at hold 3, preempts only when hold reaches 9
    for (int i = 0; i < 6; i++) begin
      tick(4'b0101, "hold0");
      expect_grant(4'b0001, "hold_keep");
    end
    tick(4'b0101, "preempt");
    expect_grant(4'b0100, "preempt_to2");
    since = 0;
    for (int i = 0; i < 8; i++) begin
      tick(4'b0101, "own2");
      since++;
      if (since >= 2 && an == 4'b1110) begin
        checks++;
        assert (seg[6:0] === 7'b1000000) else begin errs++; $error("FAIL f0f0_digit0 seg got=%b exp=%b", seg[6:0], 7'b1000000); end
      end
    end
    // 4: owner 2 drops while req0 pending, direct regrant
    tick(4'b0001, "drop2");
    expect_grant(4'b0001, "regrant0");
    // 5: sole owner req1 held long, then released
    data[31:16] = 16'hABCD;
    tick(4'b0010, "to1");
    for (int i = 0; i < 40; i++) tick(4'b0010, "sole1");
    expect_grant(4'b0010, "sole_steady");
    tick(4'b0000, "release1");
    expect_grant(4'b0000, "release_idle");
    checks++;
    assert (an === 4'hF) else begin errs++; $error("FAIL release_an got=%b exp=1111", an); end
    // random requests and live-changing data
    for (int i = 0; i < 400; i++) begin
      data = {$urandom(), $urandom()};
      if ($urandom_range(3) == 0) req = N'($urandom());
      tick(req, "random");
    end
    // 6: asynchronous reset while owned
    for (int i = 0; i < 7; i++) tick(4'b1111, "pre_rst");
    #3 reset = 0;
    #1 model_reset();
    check_all("async_rst");
    repeat (2) @(posedge clk);
    #1 check_all("in_rst");
    @(negedge clk) reset = 1;
    tick(4'b1111, "after_rst");
    expect_grant(4'b0001, "after_rst_rr");
    for (int i = 0; i < 30; i++) tick(4'b1111, "all_req");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
